// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: one single-port synchronous SRAM shared by the instruction
// fetch port and the data port. Data wins arbitration unless the instruction
// port has been denied STARVE_LIMIT cycles in a row. Byte enables, store-lane
// replication, load-lane extraction and misalignment errors are generated here.
module imem_dmem_arbiter #(
  parameter int AW           = 12,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          IREQ,
  input  logic [31:0]   IADDR,
  output logic          IGNT,
  output logic          IRDY,
  output logic [31:0]   IRDATA,
  input  logic          DREQ,
  input  logic [31:0]   DADDR,
  input  logic          DRW,
  input  logic [1:0]    DSIZE,
  input  logic [31:0]   DWDATA,
  output logic          DGNT,
  output logic          DRDY,
  output logic          DERR,
  output logic [31:0]   DRDATA,
  output logic          MCSN,
  output logic [AW-1:0] MADDR,
  output logic          MWE,
  output logic [3:0]    MBE,
  output logic [31:0]   MDI,
  input  logic [31:0]   MDO
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  logic [3:0]  starve_cnt_reg, starve_cnt_next;
  logic        starved;
  logic        i_win, d_win, d_access;
  logic        d_misaligned;
  logic [3:0]  d_be;
  logic [31:0] d_wdata;

  owner_t      owner_reg;
  logic        rw_reg;
  logic [1:0]  size_reg;
  logic [1:0]  lane_reg;
  logic        err_reg;
  logic [31:0] irdata_reg, drdata_reg;

  logic [7:0]  mdo_byte [4];
  logic [31:0] load_data;
  logic        i_rsp, d_rsp, d_load;

  // Address bits outside the SRAM word range are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{IADDR[31:AW+2], IADDR[1:0], DADDR[31:AW+2]};

  // Grant selection: data first, instruction forced through once starved.
  // Nothing is granted while reset is held.
  always_comb begin
    starved = (starve_cnt_reg == 4'(STARVE_LIMIT));
    i_win   = ~RESET & IREQ & (~DREQ | starved);
    d_win   = ~RESET & DREQ & ~i_win;
    IGNT    = i_win;
    DGNT    = d_win;
  end

  // Byte-enable decode and alignment check for the data request.
  always_comb begin
    d_misaligned = 1'b0;
    d_be         = 4'b0000;
    case (DSIZE)
      2'b00: d_be = 4'b0001 << DADDR[1:0];
      2'b01: begin
        if (DADDR[0]) d_misaligned = 1'b1;
        else          d_be = DADDR[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        if (DADDR[1:0] != 2'b00) d_misaligned = 1'b1;
        else                     d_be = 4'b1111;
      end
      default: d_misaligned = 1'b1;
    endcase
  end

  // Store data lanes: a byte fills all lanes, a halfword fills both halves.
  // Load data lanes are split out for the extraction mux.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      always_comb begin
        case (DSIZE)
          2'b00:   d_wdata[8*gi +: 8] = DWDATA[7:0];
          2'b01:   d_wdata[8*gi +: 8] = DWDATA[8*(gi%2) +: 8];
          default: d_wdata[8*gi +: 8] = DWDATA[8*gi +: 8];
        endcase
      end
      assign mdo_byte[gi] = MDO[8*gi +: 8];
    end
  endgenerate

  // SRAM drive: a misaligned data grant consumes the slot but leaves the RAM idle.
  always_comb begin
    d_access = d_win & ~d_misaligned;
    MCSN     = ~(i_win | d_access);
    MWE      = d_access & DRW;
    MBE      = 4'b0000;
    MADDR    = '0;
    MDI      = 32'h0;
    if (i_win) begin
      MBE   = 4'b1111;
      MADDR = IADDR[AW+1:2];
    end else if (d_access) begin
      MBE   = d_be;
      MADDR = DADDR[AW+1:2];
      if (DRW) MDI = d_wdata;
    end
  end

  // Starve counter: counts consecutive denied instruction cycles, saturating.
  always_comb begin
    starve_cnt_next = 4'd0;
    if (IREQ && !i_win)
      starve_cnt_next = starved ? starve_cnt_reg : starve_cnt_reg + 4'd1;
  end

  // Starve counter and response pipeline registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      starve_cnt_reg <= 4'd0;
      owner_reg      <= OWN_NONE;
      rw_reg         <= 1'b0;
      size_reg       <= 2'b00;
      lane_reg       <= 2'b00;
      err_reg        <= 1'b0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      owner_reg      <= i_win ? OWN_I : (d_win ? OWN_D : OWN_NONE);
      if (d_win) begin
        rw_reg   <= DRW;
        size_reg <= DSIZE;
        lane_reg <= DADDR[1:0];
        err_reg  <= d_misaligned;
      end
    end
  end

  // Load extraction: selected lane(s) shifted to bit 0, zero-extended.
  always_comb begin
    case (size_reg)
      2'b00:   load_data = {24'h0, mdo_byte[lane_reg]};
      2'b01:   load_data = lane_reg[1] ? {16'h0, MDO[31:16]} : {16'h0, MDO[15:0]};
      default: load_data = MDO;
    endcase
  end

  // Response outputs; read data holds between read responses.
  always_comb begin
    i_rsp  = ~RESET & (owner_reg == OWN_I);
    d_rsp  = ~RESET & (owner_reg == OWN_D);
    d_load = d_rsp & ~rw_reg & ~err_reg;
    IRDY   = i_rsp;
    DRDY   = d_rsp;
    DERR   = d_rsp & err_reg;
    IRDATA = RESET ? 32'h0 : (i_rsp ? MDO : irdata_reg);
    DRDATA = RESET ? 32'h0 : (d_load ? load_data : drdata_reg);
  end

  // Read-data hold registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      irdata_reg <= 32'h0;
      drdata_reg <= 32'h0;
    end else begin
      if (i_rsp)  irdata_reg <= MDO;
      if (d_load) drdata_reg <= load_data;
    end
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Scoreboard bench for imem_dmem_arbiter: stimulus checks grants and SRAM drive,
// and queues the expected response; a monitor pops and compares on IRDY/DRDY.
module tb_imem_dmem_arbiter;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          RESET;
  logic          IREQ, DREQ, DRW;
  logic [31:0]   IADDR, DADDR, DWDATA;
  logic [1:0]    DSIZE;
  logic          IGNT, IRDY, DGNT, DRDY, DERR;
  logic [31:0]   IRDATA, DRDATA;
  logic          MCSN, MWE;
  logic [AW-1:0] MADDR;
  logic [3:0]    MBE;
  logic [31:0]   MDI;
  logic [31:0]   mdo;

  imem_dmem_arbiter #(.AW(AW), .STARVE_LIMIT(4)) dut (
    .CLK(clk), .RESET(RESET),
    .IREQ(IREQ), .IADDR(IADDR), .IGNT(IGNT), .IRDY(IRDY), .IRDATA(IRDATA),
    .DREQ(DREQ), .DADDR(DADDR), .DRW(DRW), .DSIZE(DSIZE), .DWDATA(DWDATA),
    .DGNT(DGNT), .DRDY(DRDY), .DERR(DERR), .DRDATA(DRDATA),
    .MCSN(MCSN), .MADDR(MADDR), .MWE(MWE), .MBE(MBE), .MDI(MDI), .MDO(mdo)
  );

  always #5 clk = ~clk;

  // SRAM model: registered read, byte-enabled write.
  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (!MCSN) begin
      if (MWE) begin
        for (int b = 0; b < 4; b++)
          if (MBE[b]) mem[MADDR][8*b +: 8] = MDI[8*b +: 8];
      end else begin
        mdo <= mem[MADDR];
      end
    end
  end

  typedef struct {
    logic        is_i;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_d = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: one line per response, compared against the queue head.
  always @(negedge clk) begin
    #2;
    if (IRDY || DRDY) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", {30'h0, IRDY, DRDY}, 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("rsp %s data=%h derr=%0b", IRDY ? "I" : "D", IRDY ? IRDATA : DRDATA, DERR);
        check("rsp_owner", {31'h0, IRDY}, {31'h0, e.is_i});
        check("rsp_single", {31'h0, IRDY & DRDY}, 32'h0);
        if (e.is_i) check("irdata", IRDATA, e.data);
        else begin
          check("drdata", DRDATA, e.data);
          check("derr", {31'h0, DERR}, {31'h0, e.err});
        end
      end
    end
  end

  task automatic i_req(input logic [31:0] addr, input logic [31:0] exp_maddr,
                       input logic [31:0] exp_data);
    @(negedge clk);
    IREQ = 1'b1; IADDR = addr;
    #1;
    check("ignt", {31'h0, IGNT}, 32'h1);
    check("i_dgnt", {31'h0, DGNT}, 32'h0);
    check("i_mcsn", {31'h0, MCSN}, 32'h0);
    check("i_maddr", {20'h0, MADDR}, exp_maddr);
    check("i_mbe", {28'h0, MBE}, 32'hF);
    check("i_mwe", {31'h0, MWE}, 32'h0);
    exp_q.push_back('{is_i: 1'b1, data: exp_data, err: 1'b0});
    @(posedge clk); #1;
    IREQ = 1'b0;
  endtask

  task automatic d_req(input logic [31:0] addr, input logic rw, input logic [1:0] size,
                       input logic [31:0] wd, input logic mis, input logic [31:0] exp_maddr,
                       input logic [3:0] exp_be, input logic [31:0] exp_mdi,
                       input logic [31:0] exp_rd);
    @(negedge clk);
    DREQ = 1'b1; DADDR = addr; DRW = rw; DSIZE = size; DWDATA = wd;
    #1;
    $display("dreq addr=%h rw=%0b size=%0d mcsn=%0b mbe=%b mdi=%h", addr, rw, size, MCSN, MBE, MDI);
    check("dgnt", {31'h0, DGNT}, 32'h1);
    check("d_ignt", {31'h0, IGNT}, 32'h0);
    if (mis) begin
      check("mis_mcsn", {31'h0, MCSN}, 32'h1);
      check("mis_mbe", {28'h0, MBE}, 32'h0);
      check("mis_mwe", {31'h0, MWE}, 32'h0);
    end else begin
      check("d_mcsn", {31'h0, MCSN}, 32'h0);
      check("d_maddr", {20'h0, MADDR}, exp_maddr);
      check("d_mbe", {28'h0, MBE}, {28'h0, exp_be});
      check("d_mwe", {31'h0, MWE}, {31'h0, rw});
      if (rw) check("d_mdi", MDI, exp_mdi);
    end
    if (!rw && !mis) last_d = exp_rd;
    exp_q.push_back('{is_i: 1'b0, data: last_d, err: mis});
    @(posedge clk); #1;
    DREQ = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = 32'h0;
    mem[4] = 32'h1111_4444;
    mem[8] = 32'hBEEF_1234;
    mdo = 32'h0;
    RESET = 1'b1; IREQ = 1'b0; DREQ = 1'b0; DRW = 1'b0; DSIZE = 2'b00;
    IADDR = 32'h0; DADDR = 32'h0; DWDATA = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_ignt", {31'h0, IGNT}, 32'h0);
    check("rst_dgnt", {31'h0, DGNT}, 32'h0);
    check("rst_irdy", {31'h0, IRDY}, 32'h0);
    check("rst_drdy", {31'h0, DRDY}, 32'h0);
    check("rst_derr", {31'h0, DERR}, 32'h0);
    check("rst_irdata", IRDATA, 32'h0);
    check("rst_drdata", DRDATA, 32'h0);
    check("rst_mcsn", {31'h0, MCSN}, 32'h1);
    check("rst_mwe", {31'h0, MWE}, 32'h0);
    check("rst_mbe", {28'h0, MBE}, 32'h0);
    check("rst_maddr", {20'h0, MADDR}, 32'h0);
    check("rst_mdi", MDI, 32'h0);
    @(posedge clk); #1;
    RESET = 1'b0;

    // Instruction fetch, then data accesses
    i_req(32'h0000_0010, 32'h4, 32'h1111_4444);
    d_req(32'h103, 1'b1, 2'b00, 32'h0000_00A5, 1'b0, 32'h40, 4'b1000, 32'hA5A5_A5A5, 32'h0);
    d_req(32'h103, 1'b0, 2'b00, 32'h0,        1'b0, 32'h40, 4'b1000, 32'h0, 32'h0000_00A5);
    d_req(32'h22,  1'b0, 2'b01, 32'h0,        1'b0, 32'h8,  4'b1100, 32'h0, 32'h0000_BEEF);
    d_req(32'h20,  1'b0, 2'b01, 32'h0,        1'b0, 32'h8,  4'b0011, 32'h0, 32'h0000_1234);
    d_req(32'h21,  1'b0, 2'b00, 32'h0,        1'b0, 32'h8,  4'b0010, 32'h0, 32'h0000_0012);
    d_req(32'h22,  1'b1, 2'b01, 32'h0000_5678, 1'b0, 32'h8, 4'b1100, 32'h5678_5678, 32'h0);
    d_req(32'h20,  1'b0, 2'b10, 32'h0,        1'b0, 32'h8,  4'b1111, 32'h0, 32'h5678_1234);
    // Misaligned and illegal accesses
    d_req(32'h6,   1'b0, 2'b10, 32'h0,        1'b1, 32'h0,  4'b0000, 32'h0, 32'h0);
    d_req(32'h0,   1'b1, 2'b11, 32'h1234_5678, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0);
    d_req(32'h1,   1'b0, 2'b01, 32'h0,        1'b1, 32'h0,  4'b0000, 32'h0, 32'h0);

    // Both requesters held high: D,D,D,D,I repeating
    @(negedge clk);
    IREQ = 1'b1; IADDR = 32'h10;
    DREQ = 1'b1; DADDR = 32'h20; DRW = 1'b0; DSIZE = 2'b10;
    for (int k = 0; k < 10; k++) begin
      logic want_i;
      want_i = (k % 5 == 4);
      if (k > 0) @(negedge clk);
      #1;
      $display("arb cycle %0d ignt=%0b dgnt=%0b", k, IGNT, DGNT);
      check("arb_ignt", {31'h0, IGNT}, {31'h0, want_i});
      check("arb_dgnt", {31'h0, DGNT}, {31'h0, ~want_i});
      if (want_i) exp_q.push_back('{is_i: 1'b1, data: 32'h1111_4444, err: 1'b0});
      else begin
        last_d = 32'h5678_1234;
        exp_q.push_back('{is_i: 1'b0, data: 32'h5678_1234, err: 1'b0});
      end
      @(posedge clk); #1;
      if (want_i) check("starve_clr", {28'h0, dut.starve_cnt_reg}, 32'h0);
    end
    IREQ = 1'b0; DREQ = 1'b0;

    // Reset on top of an in-flight fetch, and with a request pending
    @(negedge clk);
    IREQ = 1'b1; IADDR = 32'h10;
    #1;
    check("pre_rst_ignt", {31'h0, IGNT}, 32'h1);
    @(posedge clk); #1;
    RESET = 1'b1;
    @(negedge clk); #1;
    check("rst_inflight_irdy", {31'h0, IRDY}, 32'h0);
    check("rst_req_ignt", {31'h0, IGNT}, 32'h0);
    check("rst_req_mcsn", {31'h0, MCSN}, 32'h1);
    @(posedge clk); #1;
    check("rst_starve", {28'h0, dut.starve_cnt_reg}, 32'h0);
    RESET = 1'b0;
    @(negedge clk); #1;
    check("post_rst_irdy", {31'h0, IRDY}, 32'h0);
    IREQ = 1'b0;
    i_req(32'h0000_0010, 32'h4, 32'h1111_4444);

    // Drain the scoreboard with a bounded wait
    for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-port synchronous SRAM (registered read data, 1-cycle latency) between the CortexM0 instruction-fetch port and data port.
- Replaces the dual-port SRAM hookup for area-reduced builds.
- Performs data-over-instruction arbitration with an anti-starvation counter.
- Generates byte enables, store-lane replication, load-lane extraction and misalignment errors.

Parameters:
- AW, 12, SRAM word-address width; MADDR = addr[AW+1:2], upper address bits ignored.
- STARVE_LIMIT, 4, consecutive denied IREQ cycles before instruction is forced to win; legal 1..15.

Ports:
- CLK  in  1  clock, all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- IREQ  in  1  instruction read request; held with IADDR until IGNT
- IADDR  in  32  instruction byte address, word aligned
- IGNT  out  1  combinational grant for the instruction request this cycle
- IRDY  out  1  one-cycle pulse, IRDATA valid
- IRDATA  out  32  fetched word
- DREQ  in  1  data request; held with DADDR/DRW/DSIZE/DWDATA until DGNT
- DADDR  in  32  data byte address
- DRW  in  1  1 = write, 0 = read
- DSIZE  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- DWDATA  in  32  store data, right-justified
- DGNT  out  1  combinational grant for the data request this cycle
- DRDY  out  1  one-cycle completion pulse for reads and writes
- DERR  out  1  pulses with DRDY on misaligned/illegal access
- DRDATA  out  32  load data, right-justified, zero-extended
- MCSN  out  1  SRAM chip select, active low
- MADDR  out  AW  SRAM word address
- MWE  out  1  SRAM write enable
- MBE  out  4  SRAM byte enables
- MDI  out  32  SRAM write data
- MDO  in  32  SRAM read data, valid the cycle after the access

Behaviour:
- Reset values: IGNT=DGNT=IRDY=DRDY=DERR=0, IRDATA=DRDATA=0, MCSN=1, MWE=0, MBE=0, MADDR=0, MDI=0.
- Reset also clears the starve counter and the response pipeline. An access granted in the cycle RESET is high produces no response afterwards.
- Arbitration is evaluated combinationally each cycle; at most one grant per cycle.
  - Only IREQ: IGNT.
  - Only DREQ: DGNT.
  - Both: DGNT, unless starve_cnt == STARVE_LIMIT, then IGNT.
- Starve counter (4 bits):
  - Increments when IREQ=1 and IGNT=0.
  - Clears when IGNT=1 or IREQ=0.
  - Saturates at STARVE_LIMIT.
- Memory drive in a granted cycle: MCSN=0, MADDR from the granted address, MWE = DGNT & DRW.
  - Instruction access: MBE=1111.
- Data byte enables, from {DSIZE, DADDR[1:0]}:
  - byte: 00→0001, 01→0010, 10→0100, 11→1000
  - halfword: 00→0011, 10→1100
  - word: 00→1111
- Store data: byte replicated to all four lanes; halfword replicated to both halves; word as-is.
- Misaligned/illegal data access (halfword with addr[0]=1, word with addr[1:0]≠0, or DSIZE=11):
  - DGNT still asserted and the slot is consumed.
  - MCSN=1, MWE=0, MBE=0 that cycle.
  - Next cycle: DRDY=1, DERR=1, DRDATA unchanged.
- Response pipeline: registers owner (none/I/D), rw, size and addr[1:0] of the granted access. Responses are fully pipelined, so back-to-back grants are allowed.
- Instruction response: cycle after IGNT, IRDY=1 and IRDATA=MDO.
- Data read response: cycle after DGNT, DRDY=1 and DRDATA = selected lane(s) of MDO shifted to bit 0, zero-extended.
- Data write response: DRDY=1 the cycle after DGNT; DRDATA unchanged.
- IRDATA/DRDATA hold their value until the next respective read response.
- Ungranted cycles: MCSN=1, MWE=0, MBE=0. MADDR/MDI are don't-care but driven 0.
- A requester dropping REQ before grant is protocol violation; no checking required.

Test Plan:
- Reset then IREQ=1, IADDR=0x0000_0010, MDO model = mem: IGNT same cycle, MADDR=4, MBE=1111; next cycle IRDY=1, IRDATA=mem[4]; all outputs 0 and MCSN=1 while RESET=1.
- Data write DSIZE=00, DADDR=0x0000_0103, DWDATA=0x0000_00A5 → MWE=1, MADDR=0x40, MBE=1000, MDI=0xA5A5_A5A5; DRDY next cycle, DERR=0. Follow with byte read of 0x103 → DRDATA=0x0000_00A5.
- Halfword read DADDR=0x22, mem[8]=0xBEEF_1234 → MBE=1100; next cycle DRDATA=0x0000_BEEF.
- IREQ and DREQ held high continuously, STARVE_LIMIT=4 → grant sequence D,D,D,D,I,D,D,D,D,I; starve_cnt returns to 0 after each IGNT.
- Misaligned word DADDR=0x6, plus DSIZE=11 case → DGNT=1, MCSN=1, MBE=0; next cycle DRDY=1, DERR=1, DRDATA unchanged.
- Assert RESET in the cycle of an IGNT → no IRDY afterwards, starve_cnt=0; first request after release is served normally.
